// File: rtl/grf_wb_arbiter_pkg.sv
// Shared definitions for the GRF writeback arbiter.
//   REG_ADDR_W : width of a general-register index
//   DATA_W     : width of a general-register value
//   wb_entry_t : one queued long-latency write {live, addr, data}
package grf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // live=0 means a younger port-A write already covered this register,
  // so the entry still occupies a slot but must not reach the GRF.
  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of long-latency register writes with kill-by-address.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, push_entry: enqueue one entry (ignored when full)
//   pop             : dequeue the head (ignored when empty)
//   head, head_valid: oldest entry and whether one exists
//   occupancy       : registered entry count, 0..DEPTH
//   kill_en, kill_addr : clear live on every queued entry with this addr
//   q_addr, q_hit   : combinational "live entry targets q_addr" lookup
module wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  head_valid,
  output logic [CNT_W-1:0]      occupancy,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_addr,
  input  logic [REG_ADDR_W-1:0] q_addr,
  output logic                  q_hit
);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok    = push && (count < CNT_W'(DEPTH));
  assign pop_ok     = pop && (count != CNT_W'(0));
  assign head       = entries[rd_ptr];
  assign head_valid = (count != CNT_W'(0));
  assign occupancy  = count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= CNT_W'(0);
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. Kills apply to existing entries only: the pushed slot is
  // written last so a same-cycle push is never killed (it is the younger).
  // Popped slots drop live so only occupied slots can ever be live.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].live <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (entries[i].addr == kill_addr)) begin
          entries[i].live <= 1'b0;
        end
      end
      if (pop_ok) begin
        entries[rd_ptr].live <= 1'b0;
      end
      if (push_ok) begin
        entries[wr_ptr] <= push_entry;
      end
    end
  end

  // Pending lookup over entries already queued; register 0 is never pending.
  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].live && (entries[i].addr == q_addr)) begin
        q_hit = 1'b1;
      end else begin
        q_hit = q_hit;
      end
    end
    if (q_addr == REG_ADDR_W'(0)) begin
      q_hit = 1'b0;
    end else begin
      q_hit = q_hit;
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Two-source writeback arbiter for the general register file.
// Port A (pipeline) has absolute priority and no backpressure; port B
// (long-latency units) is queued in order and drained when A is idle.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   a_we, a_addr, a_wd      : pipeline writeback request
//   b_valid, b_ready, b_addr, b_wd : long-latency write handshake
//   q_addr, q_pending       : decode-stage hazard query (combinational)
//   WE, RegAddr, WD         : registered GRF write port
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_we,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_wd,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_wd,
  input  logic [REG_ADDR_W-1:0] q_addr,
  output logic                  q_pending,
  output logic                  WE,
  output logic [REG_ADDR_W-1:0] RegAddr,
  output logic [DATA_W-1:0]     WD
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             a_active;
  logic             push;
  logic             pop;
  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic             head_valid;
  logic [CNT_W-1:0] occupancy;

  // A write to register 0 is a no-op and must not steal the drain slot.
  assign a_active   = a_we && (a_addr != REG_ADDR_W'(0));
  // Readiness looks only at registered occupancy, so a full queue refuses
  // even when it is being popped this cycle.
  assign b_ready    = (occupancy < CNT_W'(DEPTH));
  // Writes to register 0 complete the handshake but are dropped here.
  assign push       = b_valid && b_ready && (b_addr != REG_ADDR_W'(0));
  assign pop        = !a_active && head_valid;
  assign push_entry = '{live: 1'b1, addr: b_addr, data: b_wd};

  wb_fifo #(.DEPTH(DEPTH)) u_wb_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .occupancy  (occupancy),
    .kill_en    (a_active),
    .kill_addr  (a_addr),
    .q_addr     (q_addr),
    .q_hit      (q_pending)
  );

  // GRF write register: A first, then queue head; a killed head burns the
  // slot with WE=0. Address/data hold whenever nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      WE      <= 1'b0;
      RegAddr <= REG_ADDR_W'(0);
      WD      <= DATA_W'(0);
    end else if (a_active) begin
      WE      <= 1'b1;
      RegAddr <= a_addr;
      WD      <= a_wd;
    end else if (head_valid && head.live) begin
      WE      <= 1'b1;
      RegAddr <= head.addr;
      WD      <= head.data;
    end else begin
      WE      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed self-checking bench for grf_wb_arbiter (DEPTH=4).
module tb_grf_wb_arbiter;
  import grf_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_we;
  logic [4:0]  a_addr;
  logic [31:0] a_wd;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_wd;
  logic [4:0]  q_addr;
  logic        q_pending;
  logic        WE;
  logic [4:0]  RegAddr;
  logic [31:0] WD;

  int total = 0;
  int bad   = 0;

  grf_wb_arbiter #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wd      (a_wd),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_wd      (b_wd),
    .q_addr    (q_addr),
    .q_pending (q_pending),
    .WE        (WE),
    .RegAddr   (RegAddr),
    .WD        (WD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] ra, input logic [31:0] wd);
    chk({tag, ".WE"}, 32'(WE), 32'(we));
    chk({tag, ".RegAddr"}, 32'(RegAddr), 32'(ra));
    chk({tag, ".WD"}, WD, wd);
  endtask

  task automatic chk_pend(input string tag, input logic [4:0] addr, input logic exp);
    q_addr = addr;
    #1;
    chk(tag, 32'(q_pending), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; a_we = 1'b0; a_addr = 5'd0; a_wd = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_wd = 32'd0; q_addr = 5'd0;
    step();
    step();
    rst = 1'b0;
    chk_wr("reset", 1'b0, 5'd0, 32'h0);
    chk("reset.b_ready", 32'(b_ready), 32'd1);

    // Single A write: one-cycle latency, then WE drops and addr/data hold.
    a_we = 1'b1; a_addr = 5'd5; a_wd = 32'h1234;
    step();
    a_we = 1'b0;
    chk_wr("a_write", 1'b1, 5'd5, 32'h1234);
    step();
    chk_wr("a_idle", 1'b0, 5'd5, 32'h1234);

    // Fill queue while A keeps writing reg 9, then drain in order.
    a_we = 1'b1; a_addr = 5'd9; a_wd = 32'h99;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("fill%0d.b_ready", i), 32'(b_ready), 32'd1);
      b_valid = 1'b1; b_addr = 5'(i); b_wd = 32'hA0 + 32'(i);
      step();
      chk_wr($sformatf("fill%0d", i), 1'b1, 5'd9, 32'h99);
    end
    b_valid = 1'b0;
    chk("full.b_ready", 32'(b_ready), 32'd0);
    chk_pend("full.pend3", 5'd3, 1'b1);
    a_we = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_wr($sformatf("drain%0d", i), 1'b1, 5'(i), 32'hA0 + 32'(i));
    end
    step();
    chk_wr("drain.idle", 1'b0, 5'd4, 32'hA4);

    // Full queue, pop and b_valid together: refused, occupancy DEPTH-1.
    a_we = 1'b1; a_addr = 5'd9; a_wd = 32'h99;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_addr = 5'd12 + 5'(i); b_wd = 32'hC0 + 32'(i);
      step();
    end
    a_we = 1'b0; b_valid = 1'b1; b_addr = 5'd11; b_wd = 32'hEE;
    #1;
    chk("fullpop.b_ready", 32'(b_ready), 32'd0);
    step();
    b_valid = 1'b0;
    chk_wr("fullpop.pop", 1'b1, 5'd12, 32'hC0);
    chk("fullpop.b_ready_after", 32'(b_ready), 32'd1);
    chk_pend("fullpop.pend11", 5'd11, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_wr($sformatf("fullpop.drain%0d", i), 1'b1, 5'd12 + 5'(i), 32'hC0 + 32'(i));
    end
    step();
    chk_wr("fullpop.idle", 1'b0, 5'd15, 32'hC3);

    // Kill: queued reg 7 overtaken by an A write to reg 7.
    a_we = 1'b1; a_addr = 5'd9; a_wd = 32'h99;
    b_valid = 1'b1; b_addr = 5'd7; b_wd = 32'hBB;
    step();
    b_valid = 1'b0;
    chk_pend("kill.pend_before", 5'd7, 1'b1);
    a_addr = 5'd7; a_wd = 32'hCC;
    step();
    a_we = 1'b0;
    chk_wr("kill.a", 1'b1, 5'd7, 32'hCC);
    chk_pend("kill.pend_after", 5'd7, 1'b0);
    step();
    chk_wr("kill.pop", 1'b0, 5'd7, 32'hCC);
    step();
    chk_wr("kill.idle", 1'b0, 5'd7, 32'hCC);
    chk("kill.b_ready", 32'(b_ready), 32'd1);

    // Same-cycle push and matching A write: the push survives.
    a_we = 1'b1; a_addr = 5'd8; a_wd = 32'h77;
    b_valid = 1'b1; b_addr = 5'd8; b_wd = 32'h88;
    chk_pend("young.pend_push", 5'd8, 1'b0);
    step();
    a_we = 1'b0; b_valid = 1'b0;
    chk_wr("young.a", 1'b1, 5'd8, 32'h77);
    chk_pend("young.pend", 5'd8, 1'b1);
    step();
    chk_wr("young.b", 1'b1, 5'd8, 32'h88);

    // A on reg 0 does not block drain; B on reg 0 is accepted and dropped.
    a_we = 1'b1; a_addr = 5'd9; a_wd = 32'h99;
    b_valid = 1'b1; b_addr = 5'd3; b_wd = 32'h33;
    step();
    a_addr = 5'd0; a_wd = 32'hFFFF;
    b_addr = 5'd0; b_wd = 32'hDEAD;
    #1;
    chk("zero.b_ready", 32'(b_ready), 32'd1);
    step();
    a_we = 1'b0; b_valid = 1'b0;
    chk_wr("zero.drain", 1'b1, 5'd3, 32'h33);
    chk_pend("zero.pend0", 5'd0, 1'b0);
    step();
    chk_wr("zero.idle", 1'b0, 5'd3, 32'h33);
    chk("zero.b_ready_after", 32'(b_ready), 32'd1);

    // Reset with three queued entries and a same-cycle A write.
    a_we = 1'b1; a_addr = 5'd9; a_wd = 32'h99;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_addr = 5'd20 + 5'(i); b_wd = 32'hD0 + 32'(i);
      step();
    end
    b_valid = 1'b1; b_addr = 5'd23; b_wd = 32'hD3;
    a_addr = 5'd5; rst = 1'b1;
    step();
    rst = 1'b0; a_we = 1'b0; b_valid = 1'b0;
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.b_ready", 32'(b_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk_pend($sformatf("rst.pend%0d", 20 + i), 5'd20 + 5'(i), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rst.noq%0d", i), 32'(WE), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
